// File: rtl/crack_pkg.sv
// Shared types and helpers for the ARC4 key-search scheduler and its lanes.
package crack_pkg;

    localparam int DEFAULT_KEY_W = 24;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } sched_state_t;

    // Lanes use this to qualify a decrypted byte as plain text.
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/crack_lane_pick.sv
// Priority encoder: lowest lane index that is ready and not already holding a key.
module crack_lane_pick
    import crack_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic [NUM_LANES-1:0] lane_rdy,
    input  logic [NUM_LANES-1:0] busy,
    output logic [IDX_W-1:0]     idx,
    output logic                 found
);

    // Scan downwards so the lowest eligible index is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (lane_rdy[i] && !busy[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crack_sched.sv
// Sweeps [key_lo, key_hi] across NUM_LANES key-test lanes and reports the lowest passing key.
module crack_sched
    import crack_pkg::*;
#(
    parameter int KEY_W     = DEFAULT_KEY_W,
    parameter int NUM_LANES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    output logic                       rdy,
    input  logic [KEY_W-1:0]           key_lo,
    input  logic [KEY_W-1:0]           key_hi,
    output logic [KEY_W-1:0]           key,
    output logic                       key_valid,
    output logic [NUM_LANES-1:0]       lane_start,
    output logic [NUM_LANES*KEY_W-1:0] lane_key,
    input  logic [NUM_LANES-1:0]       lane_rdy,
    input  logic [NUM_LANES-1:0]       lane_done,
    input  logic [NUM_LANES-1:0]       lane_hit
);

    localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    sched_state_t         state_q, state_nxt;
    logic [KEY_W:0]       next_q;
    logic [KEY_W-1:0]     hi_q;
    logic [KEY_W-1:0]     best_q, best_nxt;
    logic                 best_valid_q, best_valid_nxt;
    logic [KEY_W-1:0]     key_q;
    logic                 key_valid_q;
    logic [NUM_LANES-1:0] busy_q, done_mask, busy_left, start_q;
    logic [KEY_W-1:0]     lane_key_q [NUM_LANES];
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_found;
    logic                 issue_ok, dispatch;

    crack_lane_pick #(
        .NUM_LANES (NUM_LANES),
        .IDX_W     (IDX_W)
    ) u_pick (
        .lane_rdy (lane_rdy),
        .busy     (busy_q),
        .idx      (pick_idx),
        .found    (pick_found)
    );

    assign done_mask = lane_done & busy_q;
    assign busy_left = busy_q & ~done_mask;

    // The extra counter bit lets key_hi = all-ones terminate instead of wrapping.
    assign issue_ok = (next_q <= {1'b0, hi_q}) &&
                      (!best_valid_q || (next_q < {1'b0, best_q}));
    assign dispatch = (state_q == S_RUN) && issue_ok && pick_found;

    // Simultaneous finishers are folded in lane order; the strict compare keeps the lowest key.
    always_comb begin
        best_nxt       = best_q;
        best_valid_nxt = best_valid_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (done_mask[i] && lane_hit[i] &&
                (!best_valid_nxt || (lane_key_q[i] < best_nxt))) begin
                best_nxt       = lane_key_q[i];
                best_valid_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:  if (en) state_nxt = S_RUN;
            S_RUN:   if (!issue_ok) state_nxt = S_DRAIN;
            S_DRAIN: if (busy_left == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_q       <= '0;
            hi_q         <= '0;
            best_q       <= '0;
            best_valid_q <= 1'b0;
            key_q        <= '0;
            key_valid_q  <= 1'b0;
            busy_q       <= '0;
            start_q      <= '0;
            for (int i = 0; i < NUM_LANES; i++) lane_key_q[i] <= '0;
        end else begin
            start_q      <= '0;
            busy_q       <= busy_left;
            best_q       <= best_nxt;
            best_valid_q <= best_valid_nxt;
            if (state_q == S_IDLE && en) begin
                hi_q         <= key_hi;
                next_q       <= {1'b0, key_lo};
                best_valid_q <= 1'b0;
                key_valid_q  <= 1'b0;
            end
            if (dispatch) begin
                start_q[pick_idx]    <= 1'b1;
                busy_q[pick_idx]     <= 1'b1;
                lane_key_q[pick_idx] <= next_q[KEY_W-1:0];
                next_q               <= next_q + (KEY_W + 1)'(1);
            end
            // Result is taken from the merged value so completion lands one cycle after the last lane_done.
            if (state_q == S_DRAIN && busy_left == '0) begin
                key_q       <= best_nxt;
                key_valid_q <= best_valid_nxt;
            end
        end
    end

    assign rdy        = (state_q == S_IDLE);
    assign key        = key_q;
    assign key_valid  = key_valid_q;
    assign lane_start = start_q;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane_key
        assign lane_key[g*KEY_W +: KEY_W] = lane_key_q[g];
    end

endmodule

// File: tb/tb_crack_sched.sv
// Directed bench: three scheduler instances (1, 2 and 4 lanes) driven by a shared behavioural lane model.
module tb_crack_sched;
    import crack_pkg::*;

    localparam int KW = 24;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2:0]      en_v;
    logic [KW-1:0]   key_lo, key_hi;
    wire  [2:0]      rdy_v, kv_v;
    wire  [KW-1:0]   key_o [3];
    wire  [6:0]      g_start;
    wire  [KW-1:0]   g_key [7];
    wire  [KW-1:0]   lk1;
    wire  [2*KW-1:0] lk2;
    wire  [4*KW-1:0] lk4;
    logic [6:0]      g_rdy, g_done, g_hit;

    logic [6:0]      m_busy, m_done, m_hit;
    logic [KW-1:0]   m_key [7];
    int              m_cnt [7];
    int              hit_a, hit_b;
    logic            manual;
    logic [6:0]      man_done, man_hit;

    int              total = 0;
    int              bad = 0;
    int              cyc = 0;
    int              n_start [3] = '{0, 0, 0};
    int              zero_seen [3] = '{0, 0, 0};
    int              low_cnt4 = 0;
    int              late_cnt = 0;
    int              hit_cyc = -1;
    int              phase = 0;
    logic [KW-1:0]   q1 [$];

    always #5 clk = ~clk;

    crack_sched #(.KEY_W(KW), .NUM_LANES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en_v[0]), .rdy(rdy_v[0]),
        .key_lo(key_lo), .key_hi(key_hi), .key(key_o[0]), .key_valid(kv_v[0]),
        .lane_start(g_start[0:0]), .lane_key(lk1), .lane_rdy(g_rdy[0:0]),
        .lane_done(g_done[0:0]), .lane_hit(g_hit[0:0])
    );

    crack_sched #(.KEY_W(KW), .NUM_LANES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en_v[1]), .rdy(rdy_v[1]),
        .key_lo(key_lo), .key_hi(key_hi), .key(key_o[1]), .key_valid(kv_v[1]),
        .lane_start(g_start[2:1]), .lane_key(lk2), .lane_rdy(g_rdy[2:1]),
        .lane_done(g_done[2:1]), .lane_hit(g_hit[2:1])
    );

    crack_sched #(.KEY_W(KW), .NUM_LANES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en_v[2]), .rdy(rdy_v[2]),
        .key_lo(key_lo), .key_hi(key_hi), .key(key_o[2]), .key_valid(kv_v[2]),
        .lane_start(g_start[6:3]), .lane_key(lk4), .lane_rdy(g_rdy[6:3]),
        .lane_done(g_done[6:3]), .lane_hit(g_hit[6:3])
    );

    assign g_key[0] = lk1;
    assign g_key[1] = lk2[KW-1:0];
    assign g_key[2] = lk2[2*KW-1:KW];
    for (genvar j = 0; j < 4; j++) begin : g_k4
        assign g_key[3+j] = lk4[j*KW +: KW];
    end

    assign g_rdy  = manual ? 7'h7F : ~m_busy;
    assign g_done = manual ? man_done : m_done;
    assign g_hit  = manual ? man_hit : m_hit;

    function automatic int lat_of(input int g, input logic [KW-1:0] k);
        return 3 + ((int'(k[7:0]) * 5 + g * 3) % 7);
    endfunction

    function automatic logic is_hit(input logic [KW-1:0] k);
        return (int'(k) == hit_a) || (int'(k) == hit_b);
    endfunction

    // Lane model: takes a key on lane_start, finishes after a key-dependent 3..9 cycle latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= '0;
            m_done <= '0;
            m_hit  <= '0;
            for (int g = 0; g < 7; g++) begin
                m_cnt[g] <= 0;
                m_key[g] <= '0;
            end
        end else begin
            for (int g = 0; g < 7; g++) begin
                m_done[g] <= 1'b0;
                m_hit[g]  <= 1'b0;
                if (m_busy[g]) begin
                    if (m_cnt[g] <= 1) begin
                        m_done[g] <= 1'b1;
                        m_hit[g]  <= is_hit(m_key[g]);
                        m_busy[g] <= 1'b0;
                    end else begin
                        m_cnt[g] <= m_cnt[g] - 1;
                    end
                end
                if (g_start[g]) begin
                    m_busy[g] <= 1'b1;
                    m_key[g]  <= g_key[g];
                    m_cnt[g]  <= lat_of(g, g_key[g]);
                end
            end
        end
    end

    // Dispatch log; a key above 0x30 started two or more cycles after its hit pulse is a late dispatch.
    always @(negedge clk) begin
        cyc++;
        for (int g = 0; g < 7; g++) begin
            int inst;
            inst = (g == 0) ? 0 : ((g <= 2) ? 1 : 2);
            if (g_start[g]) begin
                n_start[inst]++;
                if (g_key[g] == '0) zero_seen[inst]++;
                if (inst == 0) q1.push_back(g_key[g]);
                if (inst == 2 && g_key[g] <= 24'h30) low_cnt4++;
                if (inst == 2 && phase == 2 && hit_cyc >= 0 && g_key[g] > 24'h30 &&
                    cyc >= hit_cyc + 2) late_cnt++;
            end
            if (inst == 2 && phase == 2 && g_done[g] && g_hit[g] && m_key[g] == 24'h30)
                hit_cyc = cyc;
        end
    end

    task automatic checkOutput(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int inst, input logic [KW-1:0] lo, input logic [KW-1:0] hi);
        @(posedge clk);
        #1;
        key_lo = lo;
        key_hi = hi;
        en_v   = 3'(1 << inst);
        @(posedge clk);
        #1;
        en_v   = '0;
    endtask

    task automatic waitIdle(input int inst, input int budget, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        #1;
        while (!rdy_v[inst] && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput(tag, 96'(rdy_v[inst]), 96'(1));
    endtask

    task automatic pulseManual(input logic [6:0] done, input logic [6:0] hit);
        @(posedge clk);
        #1;
        man_done = done;
        man_hit  = hit;
        @(posedge clk);
        #1;
        man_done = '0;
        man_hit  = '0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        logic ord;

        rst_n    = 1'b1;
        en_v     = '0;
        key_lo   = '0;
        key_hi   = '0;
        manual   = 1'b0;
        man_done = '0;
        man_hit  = '0;
        hit_a    = -1;
        hit_b    = -1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_rdy", 96'(rdy_v), 96'(3'b111));
        checkOutput("rst_kv", 96'(kv_v), 96'(0));
        checkOutput("rst_key", 96'(key_o[0] | key_o[1] | key_o[2]), 96'(0));
        checkOutput("rst_start", 96'(g_start), 96'(0));
        checkOutput("rst_lkey", lk4 | 96'(lk2) | 96'(lk1), 96'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // One lane, hit only on 0x0A: keys 0..A in order and nothing past the hit.
        hit_a = 32'h0A;
        applyStimulus(0, 24'h0, 24'hF);
        waitIdle(0, 500, "t1_done");
        checkOutput("t1_count", 96'(q1.size()), 96'(11));
        ord = 1'b1;
        foreach (q1[i]) if (q1[i] != KW'(i)) ord = 1'b0;
        checkOutput("t1_order", 96'(ord), 96'(1));
        checkOutput("t1_key", 96'(key_o[0]), 96'(24'h0A));
        checkOutput("t1_kv", 96'(kv_v[0]), 96'(1));

        // Empty range on the same instance: old key held, valid cleared, idle again quickly.
        hit_a = -1;
        base  = n_start[0];
        applyStimulus(0, 24'h10, 24'h0F);
        @(negedge clk);
        #1;
        checkOutput("t4_busy", 96'(rdy_v[0]), 96'(0));
        checkOutput("t4_kv_clr", 96'(kv_v[0]), 96'(0));
        checkOutput("t4_key_hold", 96'(key_o[0]), 96'(24'h0A));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("t4_rdy3", 96'(rdy_v[0]), 96'(1));
        checkOutput("t4_kv", 96'(kv_v[0]), 96'(0));
        checkOutput("t4_nostart", 96'(n_start[0] - base), 96'(0));

        // Four lanes, hits on 0x31 and 0x30, with an en during RUN that must be ignored.
        hit_a = 32'h31;
        hit_b = 32'h30;
        phase = 2;
        applyStimulus(2, 24'h0, 24'hFF);
        repeat (10) @(posedge clk);
        #1;
        key_lo = 24'h80;
        key_hi = 24'h90;
        en_v   = 3'b100;
        @(posedge clk);
        #1;
        en_v   = '0;
        waitIdle(2, 3000, "t2_done");
        phase = 0;
        checkOutput("t2_key", 96'(key_o[2]), 96'(24'h30));
        checkOutput("t2_kv", 96'(kv_v[2]), 96'(1));
        checkOutput("t2_late", 96'(late_cnt), 96'(0));
        checkOutput("t2_low_keys", 96'(low_cnt4), 96'(49));

        // Top of the key space: two dispatches, no wrap to zero.
        hit_a = -1;
        hit_b = -1;
        base  = n_start[1];
        applyStimulus(1, 24'hFFFFFE, 24'hFFFFFF);
        waitIdle(1, 200, "t3_done");
        checkOutput("t3_count", 96'(n_start[1] - base), 96'(2));
        checkOutput("t3_nowrap", 96'(zero_seen[1]), 96'(0));
        checkOutput("t3_kv", 96'(kv_v[1]), 96'(0));

        // Hand-driven lanes: keys 7 and 5 finish together with hits; 5 must win.
        manual = 1'b1;
        base   = n_start[1];
        applyStimulus(1, 24'h5, 24'h7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("t5_two_out", 96'(n_start[1] - base), 96'(2));
        checkOutput("t5_lkeys", 96'(lk2), 96'({24'h6, 24'h5}));
        pulseManual(7'b0000100, 7'b0000000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("t5_third", 96'(n_start[1] - base), 96'(3));
        checkOutput("t5_lane1_key", 96'(lk2[2*KW-1:KW]), 96'(24'h7));
        pulseManual(7'b0000110, 7'b0000110);
        waitIdle(1, 50, "t5_done");
        checkOutput("t5_key", 96'(key_o[1]), 96'(24'h5));
        checkOutput("t5_kv", 96'(kv_v[1]), 96'(1));
        manual = 1'b0;

        // Asynchronous reset in the middle of a search, then a clean restart.
        applyStimulus(2, 24'h0, 24'hFF);
        repeat (8) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_rdy", 96'(rdy_v), 96'(3'b111));
        checkOutput("t6_rst_start", 96'(g_start), 96'(0));
        checkOutput("t6_rst_kv", 96'(kv_v), 96'(0));
        @(negedge clk);
        rst_n = 1'b1;
        hit_a = 32'h2;
        applyStimulus(2, 24'h0, 24'h3);
        waitIdle(2, 500, "t6_done");
        checkOutput("t6_key", 96'(key_o[2]), 96'(24'h2));
        checkOutput("t6_kv", 96'(kv_v[2]), 96'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
